host_bus_slave_bfm: RTL

Parametrised, synthesizable 68030 host-bus slave and bus-arbiter model for the RESDMAC benches. It replaces ad-hoc inline `_STERM` counters and `_BG` processes with one block that answers SDMAC bus-master cycles to a small memory window. It responds with `_STERM`, 32-bit `_DSACK` or 16-bit `_DSACK` after a programmable wait count, and raises `_BERR` on unmapped accesses. It sits on the CPU-side bus next to the `RESDMAC` instance, replacing the CPU/Ramsey/memory side.

---
 rtl/host_bus_slave_bfm.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/host_bus_slave_bfm.sv
// host_bus_slave_bfm: 68030 host-bus slave plus optional bus arbiter.
// Answers bus-master cycles to a DEPTH-word memory window with _STERM or
// _DSACK after WAIT_STATES clocks; unmapped accesses end in _BERR.
// Optional feature macro: BFM_ARBITER_EN (builds the _BR/_BG/_BGACK arbiter).
module host_bus_slave_bfm #(
  parameter int          WAIT_STATES  = 4,
  parameter int          ACK_MODE     = 0,
  parameter int          DEPTH        = 16,
  parameter logic [31:0] BASE_ADDR    = 32'h0800_0000,
  parameter logic [31:0] DATA_INIT    = 32'h00AB_CDEF,
  parameter logic [31:0] DATA_INC     = 32'h1100_0000,
  parameter int          BERR_TIMEOUT = 64
) (
  input  logic        SCLK,
  input  logic        _RST,
  input  logic        _AS,
  input  logic        R_W,
  input  logic [31:0] ADDR,
  input  logic [31:0] DATA_IN,
  output logic [31:0] DATA_OUT,
  output logic        DATA_OE,
  output logic        _STERM,
  output logic [1:0]  _DSACK,
  output logic        _BERR,
  input  logic        _BR,
  input  logic        _BGACK,
  output logic        _BG,
  output logic [15:0] XFER_CNT
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_ACK  = 3'd2;
  localparam logic [2:0] S_HOLD = 3'd3;
  localparam logic [2:0] S_ERR  = 3'd4;

  localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int TMAX = (BERR_TIMEOUT > WAIT_STATES) ? BERR_TIMEOUT : WAIT_STATES;
  localparam int CW   = $clog2(TMAX + 1);

  localparam logic [CW-1:0] WS_LAST  = CW'(WAIT_STATES);
  localparam logic [CW-1:0] TO_LAST  = CW'(BERR_TIMEOUT);
  localparam logic [32:0]   WIN_SIZE = 33'(4 * DEPTH);
  localparam bit            USE_STERM = (ACK_MODE == 0);
  localparam bit            HALF_PORT = (ACK_MODE == 2);
  localparam logic [1:0]    DSACK_ON  = HALF_PORT ? 2'b01 : 2'b00;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [AW-1:0] idx;
  logic          hsel;
  logic          wr;
  logic [31:0]   mem [DEPTH];

  // Window decode: the unsigned offset wraps for addresses below the base,
  // so a single compare covers both bounds.
  logic [31:0]   offs;
  logic          in_win;
  logic [AW-1:0] idx_in;
  logic [31:0]   rd_word;
  logic [31:0]   rd_data;
  logic          ack_go;

  assign offs    = ADDR - BASE_ADDR;
  assign in_win  = ({1'b0, offs} < WIN_SIZE);
  assign idx_in  = ADDR[2 +: AW];
  assign rd_word = mem[idx_in];
  // A 16-bit port presents the half picked by ADDR[1] on the upper lanes.
  assign rd_data = HALF_PORT ? {(ADDR[1] ? rd_word[15:0] : rd_word[31:16]), 16'h0000}
                             : rd_word;
  assign ack_go  = (state == S_WAIT) && !_AS && (cnt == WS_LAST);

  // Slave FSM and registered bus outputs.
  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      state    <= S_IDLE;
      cnt      <= '0;
      idx      <= '0;
      hsel     <= 1'b0;
      wr       <= 1'b0;
      DATA_OUT <= '0;
      DATA_OE  <= 1'b0;
      _STERM   <= 1'b1;
      _DSACK   <= 2'b11;
      _BERR    <= 1'b1;
      XFER_CNT <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (!_AS) begin
            cnt  <= '0;
            idx  <= idx_in;
            hsel <= ADDR[1];
            wr   <= !R_W;
            if (in_win) begin
              state <= S_WAIT;
              if (R_W) begin
                DATA_OUT <= rd_data;
                DATA_OE  <= 1'b1;
              end
            end else begin
              state <= S_ERR;
            end
          end
        end
        S_WAIT: begin
          if (_AS) begin
            // master gave up: no write, no count
            state   <= S_IDLE;
            DATA_OE <= 1'b0;
          end else if (cnt == WS_LAST) begin
            state    <= S_ACK;
            XFER_CNT <= XFER_CNT + 16'd1;
            if (USE_STERM) _STERM <= 1'b0;
            else           _DSACK <= DSACK_ON;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_ACK: begin
          state  <= S_HOLD;
          _STERM <= 1'b1;
        end
        S_HOLD: begin
          if (_AS) begin
            state   <= S_IDLE;
            _DSACK  <= 2'b11;
            DATA_OE <= 1'b0;
          end
        end
        S_ERR: begin
          if (_AS) begin
            state <= S_IDLE;
            _BERR <= 1'b1;
          end else if (_BERR) begin
            if (cnt == TO_LAST) _BERR <= 1'b0;
            else                cnt   <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory: reloads the init pattern on reset, captures writes on the ack edge.
  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= DATA_INIT + DATA_INC * 32'(i);
    end else if (ack_go && wr) begin
      if (HALF_PORT) begin
        if (hsel) mem[idx][15:0]  <= DATA_IN[31:16];
        else      mem[idx][31:16] <= DATA_IN[31:16];
      end else begin
        mem[idx] <= DATA_IN;
      end
    end
  end

`ifdef BFM_ARBITER_EN
  // Bus arbiter: grant only when the bus is idle, drop on BGACK or withdrawn request.
  always_ff @(posedge SCLK) begin
    if (!_RST) begin
      _BG <= 1'b1;
    end else if (_BG) begin
      if (!_BR && _BGACK && _AS) _BG <= 1'b0;
    end else if (!_BGACK || _BR) begin
      _BG <= 1'b1;
    end
  end
`else
  logic unused_arb;
  assign unused_arb = &{1'b0, _BR, _BGACK};
  assign _BG = 1'b1;
`endif

endmodule
